// File: rtl/g76_mem_pkg.sv
// Shared types for the memory-manager client side.
// Provides the address/data widths, the posted-write entry type and the
// write-bridge state encoding used by host_write_bridge and host_write_fifo.
package g76_mem_pkg;

    localparam int unsigned MEM_ADDR_WIDTH = 17;
    localparam int unsigned MEM_DATA_WIDTH = 8;

    typedef struct packed {
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [MEM_DATA_WIDTH-1:0] data;
    } write_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        RELEASE
    } bridge_state_t;

endpackage

// File: rtl/host_write_fifo.sv
// Circular buffer of posted host writes.
// Optional feature macro: HOST_READ_BYPASS_EN (adds an age-ordered view of all entries).
// Ports:
//   clock, reset       system clock, asynchronous active-high reset (flushes the buffer)
//   push, pushEntry    write pushEntry at the tail; ignored when full
//   pop                drop the head entry; ignored when empty
//   headEntry          oldest entry
//   count, full, empty occupancy
//   orderedEntries     (bypass only) entries by age, index 0 = oldest
//   orderedValid       (bypass only) per-slot valid for orderedEntries
module host_write_fifo
    import g76_mem_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  write_entry_t                 pushEntry,
    input  logic                         pop,
    output write_entry_t                 headEntry,
    output logic [$clog2(FIFO_DEPTH):0]  count,
    output logic                         full,
    output logic                         empty
`ifdef HOST_READ_BYPASS_EN
    ,
    output write_entry_t                 orderedEntries [FIFO_DEPTH],
    output logic [FIFO_DEPTH-1:0]        orderedValid
`endif
);

    localparam int unsigned PtrWidth   = $clog2(FIFO_DEPTH);
    localparam int unsigned CountWidth = PtrWidth + 1;

    write_entry_t          mem [FIFO_DEPTH];
    logic [PtrWidth-1:0]   wrPtrQ, rdPtrQ;
    logic [CountWidth-1:0] countQ, countD;
    logic                  pushEn, popEn;

    assign full   = (countQ == CountWidth'(FIFO_DEPTH));
    assign empty  = (countQ == '0);
    assign pushEn = push && !full;
    assign popEn  = pop && !empty;

    always_comb begin
        countD = countQ;
        unique case ({pushEn, popEn})
            2'b10:   countD = countQ + CountWidth'(1);
            2'b01:   countD = countQ - CountWidth'(1);
            default: countD = countQ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else begin
            if (pushEn) wrPtrQ <= wrPtrQ + PtrWidth'(1);
            if (popEn)  rdPtrQ <= rdPtrQ + PtrWidth'(1);
            countQ <= countD;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (pushEn) mem[wrPtrQ] <= pushEntry;
    end

    assign headEntry = mem[rdPtrQ];
    assign count     = countQ;

`ifdef HOST_READ_BYPASS_EN
    for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_view
        assign orderedEntries[i] = mem[rdPtrQ + PtrWidth'(i)];
        assign orderedValid[i]   = (CountWidth'(i) < countQ);
    end
`endif

endmodule

// File: rtl/host_write_bridge.sv
// Host-side initiator for the memory manager write/read client interface.
// Posts host writes into host_write_fifo and replays them one at a time over a
// level request / one-cycle complete handshake; forwards host reads.
// Optional feature macro: HOST_READ_BYPASS_EN (host reads snoop posted writes).
// Ports:
//   clock, reset                    system clock, asynchronous active-high reset
//   hostWriteStrobe/Address/Data    posted write from the host bus decoder
//   hostWriteReady                  FIFO has room
//   hostReadAddress, hostReadData   host read path
//   memoryWriteRequest/Address/Data level write request with held address/data
//   memoryWriteComplete             one-cycle completion from the memory manager
//   memoryReadAddress, memoryReadData  read path to the memory manager
//   pendingCount, bridgeIdle        occupancy (including in-flight entry) and idle status
//   overflowError, timeoutError     sticky error flags, cleared by errorClear
module host_write_bridge
    import g76_mem_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          hostWriteStrobe,
    input  logic [MEM_ADDR_WIDTH-1:0]     hostWriteAddress,
    input  logic [MEM_DATA_WIDTH-1:0]     hostWriteData,
    output logic                          hostWriteReady,
    input  logic [MEM_ADDR_WIDTH-1:0]     hostReadAddress,
    output logic [MEM_DATA_WIDTH-1:0]     hostReadData,
    output logic                          memoryWriteRequest,
    output logic [MEM_ADDR_WIDTH-1:0]     memoryWriteAddress,
    output logic [MEM_DATA_WIDTH-1:0]     memoryWriteData,
    input  logic                          memoryWriteComplete,
    output logic [MEM_ADDR_WIDTH-1:0]     memoryReadAddress,
    input  logic [MEM_DATA_WIDTH-1:0]     memoryReadData,
    output logic [$clog2(FIFO_DEPTH):0]   pendingCount,
    output logic                          bridgeIdle,
    output logic                          overflowError,
    output logic                          timeoutError,
    input  logic                          errorClear
);

    localparam int unsigned TimerWidth = $clog2(TIMEOUT_CYCLES + 1);

    bridge_state_t           stateQ, stateD;
    write_entry_t            headEntry;
    logic                    fifoFull, fifoEmpty;
    logic                    pushEntryEn, popEntry, latchHead;
    logic [MEM_ADDR_WIDTH-1:0] addrQ;
    logic [MEM_DATA_WIDTH-1:0] dataQ;
    logic [TimerWidth-1:0]   timerQ;
    logic                    timeoutHit;
    logic                    overflowQ, timeoutQ;

`ifdef HOST_READ_BYPASS_EN
    write_entry_t            fifoView [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifoViewValid;
`endif

    // Fullness is the registered state, so a same-cycle pop never makes room.
    assign pushEntryEn = hostWriteStrobe && !fifoFull;

    host_write_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock          (clock),
        .reset          (reset),
        .push           (pushEntryEn),
        .pushEntry      ('{addr: hostWriteAddress, data: hostWriteData}),
        .pop            (popEntry),
        .headEntry      (headEntry),
        .count          (pendingCount),
        .full           (fifoFull),
        .empty          (fifoEmpty)
`ifdef HOST_READ_BYPASS_EN
        ,
        .orderedEntries (fifoView),
        .orderedValid   (fifoViewValid)
`endif
    );

    always_comb begin
        stateD    = stateQ;
        latchHead = 1'b0;
        popEntry  = 1'b0;
        unique case (stateQ)
            IDLE: begin
                if (!fifoEmpty) begin
                    stateD    = REQUEST;
                    latchHead = 1'b1;
                end
            end
            REQUEST: begin
                if (memoryWriteComplete) begin
                    stateD   = RELEASE;
                    popEntry = 1'b1;
                end
            end
            RELEASE: stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateQ <= IDLE;
            addrQ  <= '0;
            dataQ  <= '0;
        end else begin
            stateQ <= stateD;
            if (latchHead) begin
                addrQ <= headEntry.addr;
                dataQ <= headEntry.data;
            end
        end
    end

    // Counts REQUEST cycles; saturates so the flag sets once per stuck request.
    assign timeoutHit = (stateQ == REQUEST) &&
                        (timerQ == TimerWidth'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timerQ <= '0;
        end else if (latchHead) begin
            timerQ <= '0;
        end else if ((stateQ == REQUEST) && (timerQ != TimerWidth'(TIMEOUT_CYCLES))) begin
            timerQ <= timerQ + TimerWidth'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflowQ <= 1'b0;
            timeoutQ  <= 1'b0;
        end else if (errorClear) begin
            overflowQ <= 1'b0;
            timeoutQ  <= 1'b0;
        end else begin
            if (hostWriteStrobe && fifoFull) overflowQ <= 1'b1;
            if (timeoutHit)                  timeoutQ  <= 1'b1;
        end
    end

`ifdef HOST_READ_BYPASS_EN
    // Later slots are newer, so the last match in age order wins.
    always_comb begin
        hostReadData = memoryReadData;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifoViewValid[i] && (fifoView[i].addr == hostReadAddress)) begin
                hostReadData = fifoView[i].data;
            end
        end
    end
`else
    assign hostReadData = memoryReadData;
`endif

    assign memoryWriteRequest = (stateQ == REQUEST);
    assign memoryWriteAddress = addrQ;
    assign memoryWriteData    = dataQ;
    assign memoryReadAddress  = hostReadAddress;
    assign hostWriteReady     = !fifoFull;
    assign bridgeIdle         = fifoEmpty && (stateQ == IDLE);
    assign overflowError      = overflowQ;
    assign timeoutError       = timeoutQ;

endmodule

// File: tb/tb_host_write_bridge.sv
module tb_host_write_bridge;
    import g76_mem_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        hostWriteStrobe = 1'b0;
    logic [16:0] hostWriteAddress = '0;
    logic [7:0]  hostWriteData = '0;
    logic        hostWriteReady;
    logic [16:0] hostReadAddress = '0;
    logic [7:0]  hostReadData;
    logic        memoryWriteRequest;
    logic [16:0] memoryWriteAddress;
    logic [7:0]  memoryWriteData;
    logic        memoryWriteComplete = 1'b0;
    logic [16:0] memoryReadAddress;
    logic [7:0]  memoryReadData = '0;
    logic [2:0]  pendingCount;
    logic        bridgeIdle;
    logic        overflowError;
    logic        timeoutError;
    logic        errorClear = 1'b0;

    host_write_bridge #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .hostWriteStrobe     (hostWriteStrobe),
        .hostWriteAddress    (hostWriteAddress),
        .hostWriteData       (hostWriteData),
        .hostWriteReady      (hostWriteReady),
        .hostReadAddress     (hostReadAddress),
        .hostReadData        (hostReadData),
        .memoryWriteRequest  (memoryWriteRequest),
        .memoryWriteAddress  (memoryWriteAddress),
        .memoryWriteData     (memoryWriteData),
        .memoryWriteComplete (memoryWriteComplete),
        .memoryReadAddress   (memoryReadAddress),
        .memoryReadData      (memoryReadData),
        .pendingCount        (pendingCount),
        .bridgeIdle          (bridgeIdle),
        .overflowError       (overflowError),
        .timeoutError        (timeoutError),
        .errorClear          (errorClear)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a queue of posted writes plus the request handshake rules.
    write_entry_t mq[$];
    bit          mReq = 0;
    int          mSinceFall = 3;   // edges since the request last dropped
    int          mHigh = 0;        // edges the current request has been high
    logic [16:0] mAddr = '0;
    logic [7:0]  mData = '0;
    bit          mOvf = 0;
    bit          mTmo = 0;

    function automatic void model_reset();
        mq.delete();
        mReq = 0; mSinceFall = 3; mHigh = 0;
        mAddr = '0; mData = '0; mOvf = 0; mTmo = 0;
    endfunction

    function automatic void model_step();
        int oldLen = mq.size();
        bit fullNow = (oldLen == DEPTH);
        bit setT = 0;
        if (mReq) begin
            mHigh++;
            if (mHigh == TMO) setT = 1;
        end
        if (mReq && memoryWriteComplete) begin
            void'(mq.pop_front());
            mReq = 0;
            mSinceFall = 0;
        end else begin
            if (mSinceFall < 3) mSinceFall++;
            // Two request-low edges must separate consecutive requests.
            if (!mReq && oldLen > 0 && mSinceFall >= 2) begin
                mReq = 1; mHigh = 0;
                mAddr = mq[0].addr; mData = mq[0].data;
            end
        end
        if (hostWriteStrobe && !fullNow)
            mq.push_back('{addr: hostWriteAddress, data: hostWriteData});
        if (errorClear) begin
            mOvf = 0; mTmo = 0;
        end else begin
            if (hostWriteStrobe && fullNow) mOvf = 1;
            if (setT) mTmo = 1;
        end
    endfunction

    function automatic logic [7:0] exp_read();
        logic [7:0] r = memoryReadData;
`ifdef HOST_READ_BYPASS_EN
        foreach (mq[i]) if (mq[i].addr == hostReadAddress) r = mq[i].data;
`endif
        return r;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) model_reset();
        else model_step();
        #1;
        check("request", memoryWriteRequest, mReq);
        check("wr_addr", memoryWriteAddress, mAddr);
        check("wr_data", memoryWriteData, mData);
        check("pending", pendingCount, mq.size());
        check("ready", hostWriteReady, mq.size() < DEPTH);
        check("idle", bridgeIdle, (mq.size() == 0) && !mReq && (mSinceFall >= 1));
        check("overflow", overflowError, mOvf);
        check("timeout", timeoutError, mTmo);
        check("rd_addr", memoryReadAddress, hostReadAddress);
        check("rd_data", hostReadData, exp_read());
    end

    logic [16:0] riseLog[$];

    task automatic write(input logic [16:0] a, input logic [7:0] d);
        hostWriteStrobe = 1'b1; hostWriteAddress = a; hostWriteData = d;
        @(negedge clock);
        hostWriteStrobe = 1'b0;
    endtask

    task automatic drain(input int budget);
        bit prev = 0;
        int n = 0;
        while (!(bridgeIdle && pendingCount == 0)) begin
            if (n >= budget) begin
                checks++; errors++;
                $display("FAIL drain_budget pending=%0d required=0", pendingCount);
                break;
            end
            if (memoryWriteRequest && !prev) riseLog.push_back(memoryWriteAddress);
            prev = memoryWriteRequest;
            memoryWriteComplete = memoryWriteRequest && ($urandom_range(0, 2) == 0);
            @(negedge clock);
            n++;
        end
        memoryWriteComplete = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(negedge clock);
        check("rst_request", memoryWriteRequest, 0);
        check("rst_pending", pendingCount, 0);
        check("rst_idle", bridgeIdle, 1);
        check("rst_ready", hostWriteReady, 1);
        check("rst_addr", memoryWriteAddress, 0);
        reset = 1'b0;
        @(negedge clock);

        // Single write with a complete 4 cycles after request rises.
        write(17'h12345, 8'hA5);
        check("t1_pending1", pendingCount, 1);
        check("t1_req_low", memoryWriteRequest, 0);
        @(negedge clock);
        check("t1_req_high", memoryWriteRequest, 1);
        check("t1_addr", memoryWriteAddress, 17'h12345);
        check("t1_data", memoryWriteData, 8'hA5);
        repeat (3) @(negedge clock);
        check("t1_req_held", memoryWriteRequest, 1);
        memoryWriteComplete = 1'b1;
        @(negedge clock);
        memoryWriteComplete = 1'b0;
        check("t1_req_drop", memoryWriteRequest, 0);
        check("t1_pending0", pendingCount, 0);
        check("t1_addr_held", memoryWriteAddress, 17'h12345);
        @(negedge clock);
        check("t1_idle", bridgeIdle, 1);

        // Overflow on the fifth strobe, then clear.
        for (int i = 0; i < 4; i++) write(17'h00200 + 17'(i), 8'(8'h30 + i));
        check("t2_ready_low", hostWriteReady, 0);
        write(17'h00299, 8'hEE);
        check("t2_pending4", pendingCount, 4);
        check("t2_overflow", overflowError, 1);
        errorClear = 1'b1;
        @(negedge clock);
        errorClear = 1'b0;
        check("t2_cleared", overflowError, 0);
        riseLog.delete();
        drain(200);
        check("t2_order_n", riseLog.size(), 4);

        // Four queued writes replayed in order.
        riseLog.delete();
        for (int i = 0; i < 4; i++) write(17'h01000 + 17'(i), 8'(8'h40 + i));
        drain(200);
        check("t3_n", riseLog.size(), 4);
        for (int i = 0; i < 4 && i < riseLog.size(); i++)
            check("t3_order", riseLog[i], 17'h01000 + 17'(i));

        // Withheld complete triggers timeout without dropping the entry.
        write(17'h00ABC, 8'h5C);
        @(negedge clock);
        check("t4_req", memoryWriteRequest, 1);
        repeat (15) @(negedge clock);
        check("t4_tmo_before", timeoutError, 0);
        @(negedge clock);
        check("t4_tmo_set", timeoutError, 1);
        check("t4_req_still", memoryWriteRequest, 1);
        repeat (3) @(negedge clock);
        memoryWriteComplete = 1'b1;
        @(negedge clock);
        memoryWriteComplete = 1'b0;
        check("t4_popped", pendingCount, 0);
        errorClear = 1'b1;
        @(negedge clock);
        errorClear = 1'b0;
        check("t4_cleared", timeoutError, 0);

        // Reset in the middle of a request.
        write(17'h00777, 8'h77);
        n = 0;
        while (!memoryWriteRequest && n < 10) begin @(negedge clock); n++; end
        check("t5_req_up", memoryWriteRequest, 1);
        #3 reset = 1'b1;
        #1;
        check("t5_req_async", memoryWriteRequest, 0);
        check("t5_flushed", pendingCount, 0);
        @(negedge clock);
        reset = 1'b0;
        memoryWriteComplete = 1'b1;
        @(negedge clock);
        memoryWriteComplete = 1'b0;
        check("t5_no_underflow", pendingCount, 0);
        @(negedge clock);
        check("t5_idle", bridgeIdle, 1);

`ifdef HOST_READ_BYPASS_EN
        // Read bypass picks the newest matching posted write.
        memoryReadData = 8'h5A;
        hostReadAddress = 17'h00100;
        write(17'h00100, 8'h11);
        write(17'h00100, 8'h22);
        #1;
        check("t6_bypass", hostReadData, 8'h22);
        drain(200);
        #1;
        check("t6_after", hostReadData, 8'h5A);
`endif

        // Randomized traffic, including a quiet window and an async reset.
        for (int c = 0; c < 900; c++) begin
            hostWriteStrobe  = ($urandom_range(0, 9) < 4);
            hostWriteAddress = 17'h00100 + 17'($urandom_range(0, 7));
            hostWriteData    = 8'($urandom);
            hostReadAddress  = 17'h00100 + 17'($urandom_range(0, 7));
            memoryReadData   = 8'($urandom);
            errorClear       = ($urandom_range(0, 49) == 0);
            if (c >= 400 && c < 460) memoryWriteComplete = 1'b0;
            else memoryWriteComplete = ($urandom_range(0, 3) == 0);
            if (c == 700) begin
                #3 reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
            end else begin
                @(negedge clock);
            end
        end
        hostWriteStrobe = 1'b0;
        errorClear = 1'b0;
        drain(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
